// File: rtl/vga_pkg.sv
// Shared timing constants and small helpers for the VGA text-path timing stage.
// Defaults describe 640x480@60 with an 8x16 glyph cell.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W      = 10;
  localparam int CHAR_COL_W = 7;
  localparam int CHAR_ROW_W = 5;

  // Pixel-aligned video timing bits; sync levels are active low.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

  function automatic logic in_window(input logic [CNT_W-1:0] value,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single-axis pixel/line counter: wraps at TOTAL-1, exposes the next and
// following count for look-ahead, and registers the sync level of the next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = vga_pkg::H_ACTIVE,
  parameter int FP     = vga_pkg::H_FP,
  parameter int SYNC   = vga_pkg::H_SYNC,
  parameter int BP     = vga_pkg::H_BP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] next_o,
  output logic [CNT_W-1:0] look_o,
  output logic             wrap_o,
  output logic             next_last_o,
  output logic             sync_n_o,
  output logic             active_next_o
);

  localparam int               TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_n_q, sync_n_d;

  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    wrap_o        = en_i && (cnt_q == LAST);
    next_last_o   = (cnt_d == LAST);
    look_o        = next_last_o ? '0 : cnt_d + 1'b1;
    sync_n_d      = !in_window(cnt_d, SYNC_LO, SYNC_HI);
    active_next_o = (cnt_d < ACT_END);
  end

  // NOTE: state is written with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      sync_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign next_o   = cnt_d;
  assign sync_n_o = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing stage: pixel/line counters, syncs and glyph prefetch strobes for the text path.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/activeVideo by one enabled pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CHAR_W   = vga_pkg::CHAR_W,
  parameter int CHAR_H   = vga_pkg::CHAR_H
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pixEn,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      activeVideo,
  output logic [CNT_W-1:0]          hCnt,
  output logic [CNT_W-1:0]          vCnt,
  output logic                      rowEn,
  output logic                      colEn,
  output logic [$clog2(CHAR_H)-1:0] glyphRow,
  output logic [$clog2(CHAR_W)-1:0] pixCol,
  output logic [CHAR_COL_W-1:0]     charCol,
  output logic [CHAR_ROW_W-1:0]     charRow,
  output logic                      frameStart
);

  localparam int               GW       = $clog2(CHAR_W);
  localparam int               GH       = $clog2(CHAR_H);
  localparam logic [CNT_W-1:0] H_ACT_W  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_W  = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_next, h_look, v_next, v_look, nv_look;
  logic             h_wrap, h_next_last, h_sync_n, h_act_n;
  logic             v_wrap, v_next_last, v_sync_n, v_act_n;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clock        (clock),
    .reset        (reset),
    .en_i         (pixEn),
    .cnt_o        (hCnt),
    .next_o       (h_next),
    .look_o       (h_look),
    .wrap_o       (h_wrap),
    .next_last_o  (h_next_last),
    .sync_n_o     (h_sync_n),
    .active_next_o(h_act_n)
  );

  // The vertical axis only advances on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clock        (clock),
    .reset        (reset),
    .en_i         (h_wrap),
    .cnt_o        (vCnt),
    .next_o       (v_next),
    .look_o       (v_look),
    .wrap_o       (v_wrap),
    .next_last_o  (v_next_last),
    .sync_n_o     (v_sync_n),
    .active_next_o(v_act_n)
  );

  logic                  active_q, active_d;
  logic                  row_en_q, row_en_d;
  logic                  col_en_q, col_en_d;
  logic                  frame_start_q, frame_start_d;
  logic [GH-1:0]         glyph_row_q, glyph_row_d;
  logic [GW-1:0]         pix_col_q, pix_col_d;
  logic [CHAR_COL_W-1:0] char_col_q, char_col_d;
  logic [CHAR_ROW_W-1:0] char_row_q, char_row_d;

  // Look-ahead targets the pixel after the one being loaded, so strobes land one pixel early.
  always_comb begin
    nv_look       = h_next_last ? v_look : v_next;
    active_d      = h_act_n && v_act_n;
    row_en_d      = (nv_look < V_ACT_W);
    col_en_d      = pixEn && (h_look < H_ACT_W) && (h_look[GW-1:0] == '0);
    char_col_d    = col_en_d ? h_look[GW +: CHAR_COL_W] : char_col_q;
    frame_start_d = v_wrap;
    glyph_row_d   = v_next[GH-1:0];
    char_row_d    = v_next[GH +: CHAR_ROW_W];
    pix_col_d     = ~h_next[GW-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q      <= 1'b0;
      row_en_q      <= 1'b0;
      col_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      glyph_row_q   <= '0;
      pix_col_q     <= '0;
      char_col_q    <= '0;
      char_row_q    <= '0;
    end else begin
      col_en_q      <= col_en_d;
      frame_start_q <= frame_start_d;
      if (pixEn) begin
        active_q    <= active_d;
        row_en_q    <= row_en_d;
        char_col_q  <= char_col_d;
        glyph_row_q <= glyph_row_d;
        pix_col_q   <= pix_col_d;
        char_row_q  <= char_row_d;
      end
    end
  end

  // Upper count bits beyond the cell fields carry no extra information here.
  logic unused_bits;
  assign unused_bits = ^{h_next[CNT_W-1:GW], v_next[CNT_W-1:GH+CHAR_ROW_W], v_next_last};

`ifdef VGA_SYNC_DELAY_EN
  sync_t sync_dly_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_dly_q <= SYNC_IDLE;
    end else if (pixEn) begin
      sync_dly_q <= '{hsync: h_sync_n, vsync: v_sync_n, active: active_q};
    end
  end

  assign hsync       = sync_dly_q.hsync;
  assign vsync       = sync_dly_q.vsync;
  assign activeVideo = sync_dly_q.active;
`else
  assign hsync       = h_sync_n;
  assign vsync       = v_sync_n;
  assign activeVideo = active_q;
`endif

  assign rowEn      = row_en_q;
  assign colEn      = col_en_q;
  assign frameStart = frame_start_q;
  assign glyphRow   = glyph_row_q;
  assign pixCol     = pix_col_q;
  assign charCol    = char_col_q;
  assign charRow    = char_row_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster (96x40) with 8x16 cells.
// A pixel model pushes the expected outputs per clock; each observation pops and compares.
module tb_vga_timing_gen;

  localparam int HA = 64, HF = 8, HS = 16, HB = 8;
  localparam int VA = 32, VF = 3, VS = 2, VB = 3;
  localparam int CW = 8, CH = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  typedef struct packed {
    logic       hs, vs, av;
    logic [9:0] hc, vc;
    logic       re, ce;
    logic [3:0] gr;
    logic [2:0] pc;
    logic [6:0] cc;
    logic [4:0] cr;
    logic       fs;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pixEn = 1'b0;
  logic       hsync, vsync, activeVideo, rowEn, colEn, frameStart;
  logic [9:0] hCnt, vCnt;
  logic [3:0] glyphRow;
  logic [2:0] pixCol;
  logic [6:0] charCol;
  logic [4:0] charRow;

  always #5 clock = ~clock;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CHAR_W(CW), .CHAR_H(CH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pixEn      (pixEn),
    .hsync      (hsync),
    .vsync      (vsync),
    .activeVideo(activeVideo),
    .hCnt       (hCnt),
    .vCnt       (vCnt),
    .rowEn      (rowEn),
    .colEn      (colEn),
    .glyphRow   (glyphRow),
    .pixCol     (pixCol),
    .charCol    (charCol),
    .charRow    (charRow),
    .frameStart (frameStart)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int         mh, mv;
  logic [6:0] m_cc;
  logic [2:0] m_und, m_dly;
  obs_t       m_last;
  obs_t       exp_q[$];

  // Observation statistics
  int cyc = 0;
  int fs_hist[$];
  int hs_run, hs_low_len, hs_fall_h, av_fall_h, vs_fall_v, vs_rise_v;
  int col_line0, off_strobes;
  int cc_at7, pc_at, gr_at, cr_at;
  logic prev_hs, prev_av, prev_vs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic obs_t reset_exp();
    obs_t e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  function automatic logic [2:0] und(input int h, input int v);
    logic hs, vs, av;
    hs = !(h >= HA + HF && h < HA + HF + HS);
    vs = !(v >= VA + VF && v < VA + VF + VS);
    av = (h < HA) && (v < VA);
    return {hs, vs, av};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; m_cc = '0;
    m_und = 3'b110; m_dly = 3'b110;
    m_last = reset_exp();
    exp_q.delete();
    prev_hs = 1'b1; prev_vs = 1'b1; prev_av = 1'b0; hs_run = 0;
  endtask

  task automatic drive(input bit en);
    obs_t e, got;
    int   nh, nv;
    pixEn = en;
    if (!en) begin
      e = m_last;
      e.ce = 1'b0;
      e.fs = 1'b0;
    end else begin
      m_dly = m_und;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      m_und = und(mh, mv);
      nh = (mh + 1) % HT;
      nv = (mh == HT - 1) ? (mv + 1) % VT : mv;
      {e.hs, e.vs, e.av} = (DLY != 0) ? m_dly : m_und;
      e.hc = 10'(mh);
      e.vc = 10'(mv);
      e.re = (nv < VA);
      e.ce = (nh < HA) && (nh % CW == 0);
      if (e.ce) m_cc = 7'(nh / CW);
      e.cc = m_cc;
      e.gr = 4'(mv % CH);
      e.cr = 5'(mv / CH);
      e.pc = 3'(CW - 1 - mh % CW);
      e.fs = (mh == 0) && (mv == 0);
    end
    m_last = e;
    exp_q.push_back(e);

    @(posedge clock);
    @(negedge clock);
    cyc++;
    got = {hsync, vsync, activeVideo, hCnt, vCnt, rowEn, colEn,
           glyphRow, pixCol, charCol, charRow, frameStart};
    check("pixel", got, exp_q.pop_front());

    if (got.fs) fs_hist.push_back(cyc);
    if (!got.hs) hs_run++;
    else if (hs_run > 0) begin hs_low_len = hs_run; hs_run = 0; end
    if (prev_hs && !got.hs) hs_fall_h = int'(got.hc);
    if (prev_av && !got.av) av_fall_h = int'(got.hc);
    if (prev_vs && !got.vs) vs_fall_v = int'(got.vc);
    if (!prev_vs && got.vs) vs_rise_v = int'(got.vc);
    prev_hs = got.hs; prev_av = got.av; prev_vs = got.vs;
    if (got.ce && got.vc == 0 && fs_hist.size() == 1) col_line0++;
    if (got.hc == 7 && got.vc == 0) cc_at7 = int'(got.cc);
    if (got.hc == 9 && got.vc == 17) begin
      pc_at = int'(got.pc); gr_at = int'(got.gr); cr_at = int'(got.cr);
    end
    if (!en && (got.ce || got.fs)) off_strobes++;
  endtask

  initial begin
    obs_t got;
    int   mark, period;

    hs_low_len = -1; hs_fall_h = -1; av_fall_h = -1; vs_fall_v = -1; vs_rise_v = -1;
    col_line0 = 0; off_strobes = 0; cc_at7 = -1; pc_at = -1; gr_at = -1; cr_at = -1;

    // Reset state
    repeat (3) @(negedge clock);
    got = {hsync, vsync, activeVideo, hCnt, vCnt, rowEn, colEn,
           glyphRow, pixCol, charCol, charRow, frameStart};
    check("reset_state", got, reset_exp());
    model_reset();
    reset = 1'b0;

    // Free-running pixel clock for two frames
    for (int i = 0; i < 2 * FRAME + 10; i++) drive(1'b1);
    check("fs_count", fs_hist.size(), 2);
    check("fs_first", (fs_hist.size() > 0) ? fs_hist[0] : -1, FRAME);
    period = (fs_hist.size() > 1) ? fs_hist[1] - fs_hist[0] : -1;
    check("fs_period", period, FRAME);
    check("hsync_len", hs_low_len, HS);
    check("hsync_fall", hs_fall_h, HA + HF + DLY);
    check("active_fall", av_fall_h, HA + DLY);
    check("vsync_fall", vs_fall_v, VA + VF);
    check("vsync_rise", vs_rise_v, VA + VF + VS);
    check("col_per_line", col_line0, HA / CW);
    check("charcol_at7", cc_at7, 1);
    check("pixcol_9_17", pc_at, 6);
    check("glyphrow_17", gr_at, 1);
    check("charrow_17", cr_at, 1);

    // pixEn toggling halves the pixel rate
    fs_hist.delete();
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      drive(1'b1);
      drive(1'b0);
    end
    period = (fs_hist.size() > 1) ? fs_hist[1] - fs_hist[0] : -1;
    check("fs_period_half", period, 2 * FRAME);
    check("strobe_while_off", off_strobes, 0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < FRAME && !(mh == 30 && mv == 20); i++) drive(1'b1);
    check("pre_reset_h", hCnt, 30);
    reset = 1'b1;
    #1;
    got = {hsync, vsync, activeVideo, hCnt, vCnt, rowEn, colEn,
           glyphRow, pixCol, charCol, charRow, frameStart};
    check("reset_async", got, reset_exp());
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    fs_hist.delete();
    mark = cyc;
    for (int i = 0; i < FRAME + 4; i++) drive(1'b1);
    check("fs_after_reset", (fs_hist.size() > 0) ? fs_hist[0] - mark : -1, FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
